// File: rtl/rv32_pipeline_ctrl_pkg.sv
// Shared pipeline types for the RV32 hazard controller: bypass selects, controller FSM
// states and the default performance-counter width.
package rv32_pipeline_ctrl_pkg;

    localparam int unsigned PerfWDefault = 32;

    typedef enum logic [1:0] {
        BYPASS_NONE      = 2'd0,
        BYPASS_EXEC_BUFF = 2'd1,
        BYPASS_MEM_BUFF  = 2'd2
    } bypass_t;

    typedef enum logic [1:0] {
        PC_RUN           = 2'd0,
        PC_DMEM_WAIT     = 2'd1,
        PC_REDIRECT_WAIT = 2'd2
    } pctrl_state_t;

    // x0 is hard-wired to zero, so it never produces a forwarding hit.
    function automatic logic reg_match(input logic [4:0] rs, input logic [4:0] rd);
        return (rs != 5'd0) && (rs == rd);
    endfunction

endpackage

// File: rtl/rv32_bypass_sel.sv
// Per-source forwarding select plus load-use detect for one operand of the decode stage.
module rv32_bypass_sel
    import rv32_pipeline_ctrl_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic       uses_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_wb_en_i,
    input  logic       ex_is_load_i,
    input  logic [4:0] mb_rd_i,
    input  logic       mb_wb_en_i,
    output bypass_t    bypass_o,
    output logic       load_use_o
);

    logic ex_hit;
    logic mb_hit;

    assign ex_hit = reg_match(rs_i, ex_rd_i);
    assign mb_hit = reg_match(rs_i, mb_rd_i);

    // The exec buffer holds the younger producer, so it wins over mem.
    always_comb begin
        bypass_o = BYPASS_NONE;
        if (ex_wb_en_i && ex_hit) begin
            bypass_o = BYPASS_EXEC_BUFF;
        end else if (mb_wb_en_i && mb_hit) begin
            bypass_o = BYPASS_MEM_BUFF;
        end
    end

    assign load_use_o = uses_i && ex_is_load_i && ex_hit;

endmodule

// File: rtl/rv32_pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: stage stops, NOP bubbles,
// operand bypass selects, memory/redirect wait FSM and performance counters.
module rv32_pipeline_ctrl
    import rv32_pipeline_ctrl_pkg::*;
#(
    parameter int unsigned PERF_W = PerfWDefault
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic [4:0]        dec_rs1_i,
    input  logic [4:0]        dec_rs2_i,
    input  logic              dec_uses_rs1_i,
    input  logic              dec_uses_rs2_i,
    input  logic [4:0]        ex_rd_i,
    input  logic              ex_wb_en_i,
    input  logic              ex_is_load_i,
    input  logic [4:0]        mb_rd_i,
    input  logic              mb_wb_en_i,
    input  logic              do_jump_i,
    input  logic              imem_ready_i,
    input  logic              dmem_req_i,
    input  logic              dmem_ready_i,
    output bypass_t           bypass_rs1_o,
    output bypass_t           bypass_rs2_o,
    output logic              stop_fetch_o,
    output logic              stop_decode_o,
    output logic              stop_exec_o,
    output logic              stop_mem_o,
    output logic              bubble_fetch_o,
    output logic              bubble_decode_o,
    output logic [PERF_W-1:0] stall_cycles_o,
    output logic [PERF_W-1:0] flush_count_o
);

    pctrl_state_t      state_q, state_d;
    logic [PERF_W-1:0] stall_q, stall_d;
    logic [PERF_W-1:0] flush_q, flush_d;

    bypass_t byp_rs1, byp_rs2;
    logic    lu_rs1, lu_rs2;
    logic    load_use;
    logic    freeze;
    logic    jump_accept;
    logic    any_stop;

    rv32_bypass_sel u_bypass_rs1 (
        .rs_i         (dec_rs1_i),
        .uses_i       (dec_uses_rs1_i),
        .ex_rd_i      (ex_rd_i),
        .ex_wb_en_i   (ex_wb_en_i),
        .ex_is_load_i (ex_is_load_i),
        .mb_rd_i      (mb_rd_i),
        .mb_wb_en_i   (mb_wb_en_i),
        .bypass_o     (byp_rs1),
        .load_use_o   (lu_rs1)
    );

    rv32_bypass_sel u_bypass_rs2 (
        .rs_i         (dec_rs2_i),
        .uses_i       (dec_uses_rs2_i),
        .ex_rd_i      (ex_rd_i),
        .ex_wb_en_i   (ex_wb_en_i),
        .ex_is_load_i (ex_is_load_i),
        .mb_rd_i      (mb_rd_i),
        .mb_wb_en_i   (mb_wb_en_i),
        .bypass_o     (byp_rs2),
        .load_use_o   (lu_rs2)
    );

    assign bypass_rs1_o = resetn_i ? byp_rs1 : BYPASS_NONE;
    assign bypass_rs2_o = resetn_i ? byp_rs2 : BYPASS_NONE;
    assign load_use     = lu_rs1 || lu_rs2;

    // Residency in DMEM_WAIT ends on dmem_ready alone; elsewhere a pending access freezes.
    assign freeze = (state_q == PC_DMEM_WAIT) ? !dmem_ready_i : (dmem_req_i && !dmem_ready_i);

    always_comb begin
        state_d         = state_q;
        stop_fetch_o    = 1'b0;
        stop_decode_o   = 1'b0;
        stop_exec_o     = 1'b0;
        stop_mem_o      = 1'b0;
        bubble_fetch_o  = 1'b0;
        bubble_decode_o = 1'b0;
        jump_accept     = 1'b0;

        if (!resetn_i) begin
            bubble_fetch_o  = 1'b1;
            bubble_decode_o = 1'b1;
            state_d         = PC_RUN;
        end else if (freeze) begin
            stop_fetch_o  = 1'b1;
            stop_decode_o = 1'b1;
            stop_exec_o   = 1'b1;
            stop_mem_o    = 1'b1;
            // A stale fetch response can still drain while the rest of the pipe is frozen.
            if (state_q == PC_REDIRECT_WAIT) begin
                bubble_fetch_o = 1'b1;
                if (imem_ready_i) begin
                    state_d = PC_RUN;
                end
            end else begin
                state_d = PC_DMEM_WAIT;
            end
        end else begin
            if (do_jump_i) begin
                bubble_fetch_o  = 1'b1;
                bubble_decode_o = 1'b1;
                jump_accept     = 1'b1;
            end else if (load_use) begin
                stop_fetch_o    = 1'b1;
                stop_decode_o   = 1'b1;
                bubble_decode_o = 1'b1;
            end else if (!imem_ready_i) begin
                bubble_fetch_o = 1'b1;
            end

            if (state_q == PC_REDIRECT_WAIT) begin
                bubble_fetch_o = 1'b1;
                if (!do_jump_i && imem_ready_i) begin
                    state_d = PC_RUN;
                end
            end else begin
                state_d = (do_jump_i && !imem_ready_i) ? PC_REDIRECT_WAIT : PC_RUN;
            end
        end
    end

    assign any_stop = stop_fetch_o || stop_decode_o || stop_exec_o || stop_mem_o;
    assign stall_d  = any_stop ? stall_q + PERF_W'(1) : stall_q;
    assign flush_d  = jump_accept ? flush_q + PERF_W'(1) : flush_q;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= PC_RUN;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles_o = stall_q;
    assign flush_count_o  = flush_q;

endmodule

// File: tb/tb_rv32_pipeline_ctrl.sv
// Scoreboard bench for rv32_pipeline_ctrl: expected controls are queued as stimulus is driven
// and popped at the falling edge when the combinational outputs are settled.
module tb_rv32_pipeline_ctrl;
    import rv32_pipeline_ctrl_pkg::*;

    typedef struct packed {
        logic [1:0] b1;
        logic [1:0] b2;
        logic [3:0] stop;
        logic [1:0] bub;
        logic       jacc;
    } exp_t;

    logic        clk, resetn;
    logic [4:0]  dec_rs1, dec_rs2, ex_rd, mb_rd;
    logic        dec_uses_rs1, dec_uses_rs2, ex_wb_en, ex_is_load, mb_wb_en;
    logic        do_jump, imem_ready, dmem_req, dmem_ready;
    bypass_t     bypass_rs1, bypass_rs2;
    logic        stop_fetch, stop_decode, stop_exec, stop_mem, bubble_fetch, bubble_decode;
    logic [31:0] stall_cycles, flush_count;

    exp_t        sb_q[$];
    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    int unsigned exp_stall = 0;
    int unsigned exp_flush = 0;

    rv32_pipeline_ctrl #(.PERF_W(32)) dut (
        .clk_i          (clk),
        .resetn_i       (resetn),
        .dec_rs1_i      (dec_rs1),
        .dec_rs2_i      (dec_rs2),
        .dec_uses_rs1_i (dec_uses_rs1),
        .dec_uses_rs2_i (dec_uses_rs2),
        .ex_rd_i        (ex_rd),
        .ex_wb_en_i     (ex_wb_en),
        .ex_is_load_i   (ex_is_load),
        .mb_rd_i        (mb_rd),
        .mb_wb_en_i     (mb_wb_en),
        .do_jump_i      (do_jump),
        .imem_ready_i   (imem_ready),
        .dmem_req_i     (dmem_req),
        .dmem_ready_i   (dmem_ready),
        .bypass_rs1_o   (bypass_rs1),
        .bypass_rs2_o   (bypass_rs2),
        .stop_fetch_o   (stop_fetch),
        .stop_decode_o  (stop_decode),
        .stop_exec_o    (stop_exec),
        .stop_mem_o     (stop_mem),
        .bubble_fetch_o (bubble_fetch),
        .bubble_decode_o(bubble_decode),
        .stall_cycles_o (stall_cycles),
        .flush_count_o  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic [4:0] erd, input logic ewb,
                          input logic eld, input logic [4:0] mrd, input logic mwb,
                          input logic jmp, input logic irdy, input logic dreq,
                          input logic drdy);
        dec_rs1 = rs1; dec_rs2 = rs2; dec_uses_rs1 = u1; dec_uses_rs2 = u2;
        ex_rd = erd; ex_wb_en = ewb; ex_is_load = eld; mb_rd = mrd; mb_wb_en = mwb;
        do_jump = jmp; imem_ready = irdy; dmem_req = dreq; dmem_ready = drdy;
    endtask

    // Queue the expectation for the inputs just driven, compare at negedge, then advance.
    task automatic step(input string tag, input logic [1:0] b1, input logic [1:0] b2,
                        input logic [3:0] stop, input logic [1:0] bub, input logic jacc);
        exp_t e;
        e = '{b1: b1, b2: b2, stop: stop, bub: bub, jacc: jacc};
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check_eq({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, ".byp1"}, 32'(bypass_rs1), 32'(e.b1));
            check_eq({tag, ".byp2"}, 32'(bypass_rs2), 32'(e.b2));
            check_eq({tag, ".stop"}, 32'({stop_fetch, stop_decode, stop_exec, stop_mem}),
                     32'(e.stop));
            check_eq({tag, ".bub"}, 32'({bubble_fetch, bubble_decode}), 32'(e.bub));
            if (resetn) begin
                if (e.stop != 4'b0) exp_stall++;
                if (e.jacc) exp_flush++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, ".stall"}, stall_cycles, exp_stall);
        check_eq({tag, ".flush"}, flush_count, exp_flush);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        localparam bypass_t N = BYPASS_NONE;
        localparam bypass_t E = BYPASS_EXEC_BUFF;
        localparam bypass_t M = BYPASS_MEM_BUFF;

        // Reset held with every hazard input active: outputs must still read as idle RUN.
        resetn = 1'b0;
        set_in(5'd0, 5'd3, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step("rst", N, N, 4'b0000, 2'b11, 1'b0);
        check_counters("rst");
        resetn = 1'b1;

        // Bypass selection
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("byp_ex", E, N, 4'b0000, 2'b00, 1'b0);
        set_in(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("byp_zero", N, N, 4'b0000, 2'b00, 1'b0);
        set_in(5'd7, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("byp_mix", M, E, 4'b0000, 2'b00, 1'b0);
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("byp_nowb", M, N, 4'b0000, 2'b00, 1'b0);

        // Load-use: an unused source must not stall; a used one costs one bubble.
        set_in(5'd0, 5'd3, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("lu_unused", N, E, 4'b0000, 2'b00, 1'b0);
        set_in(5'd0, 5'd3, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("lu", N, E, 4'b1100, 2'b01, 1'b0);
        set_in(5'd0, 5'd3, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("lu_next", N, M, 4'b0000, 2'b00, 1'b0);
        check_counters("lu");

        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("imiss", N, N, 4'b0000, 2'b10, 1'b0);

        // Jump overrides load-use
        set_in(5'd0, 5'd3, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("jmp_lu", N, E, 4'b0000, 2'b11, 1'b1);
        check_counters("jmp_lu");

        // Data memory wait of 3 cycles with a jump held across it
        for (int i = 0; i < 3; i++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            step("dwait", N, N, 4'b1111, 2'b00, 1'b0);
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step("drel", N, N, 4'b0000, 2'b11, 1'b1);
        check_counters("dwait");

        // Redirect wait: jump with fetch pending, two more misses, stale response discarded.
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("redir0", N, N, 4'b0000, 2'b11, 1'b1);
        for (int i = 0; i < 2; i++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step("redir_wait", N, N, 4'b0000, 2'b10, 1'b0);
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("redir_rel", N, N, 4'b0000, 2'b10, 1'b0);
        step("redir_run", N, N, 4'b0000, 2'b00, 1'b0);
        check_counters("redir");

        // Asynchronous reset in the middle of a data memory wait
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("d6", N, N, 4'b1111, 2'b00, 1'b0);
        #2;
        check_eq("d6_hold.stop", 32'({stop_fetch, stop_decode, stop_exec, stop_mem}), 32'hf);
        resetn = 1'b0;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        check_eq("arst.stop", 32'({stop_fetch, stop_decode, stop_exec, stop_mem}), 32'h0);
        check_eq("arst.bub", 32'({bubble_fetch, bubble_decode}), 32'h3);
        check_counters("arst");
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        step("post_rst", N, N, 4'b0000, 2'b00, 1'b0);
        check_counters("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
